// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall/load encodings, bus payload structs and
// FSM state type for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned HILO_WD      = 66;
  localparam int unsigned DATA_WD      = 32;
  localparam int unsigned REG_ADDR_WD  = 5;
  localparam int unsigned STALL_BUS_WD = 6;
  localparam int unsigned STALL_MEM    = 3;
  localparam int unsigned STALL_WB     = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  // EX -> MEM payload (141 bits)
  typedef struct packed {
    logic [HILO_WD-1:0]     hilo_bus;
    logic [DATA_WD-1:0]     pc;
    logic                   mem_re;
    logic                   mem_we;
    logic [2:0]             ld_op;
    logic                   rf_we;
    logic [REG_ADDR_WD-1:0] rf_waddr;
    logic [DATA_WD-1:0]     ex_result;
  } ex_to_mem_t;

  // MEM -> WB payload (136 bits)
  typedef struct packed {
    logic [HILO_WD-1:0]     hilo_bus;
    logic [DATA_WD-1:0]     pc;
    logic                   rf_we;
    logic [REG_ADDR_WD-1:0] rf_waddr;
    logic [DATA_WD-1:0]     rf_wdata;
  } mem_to_wb_t;

  // MEM -> ID forwarding payload (38 bits)
  typedef struct packed {
    logic                   fwd_we;
    logic [REG_ADDR_WD-1:0] rf_waddr;
    logic [DATA_WD-1:0]     rf_wdata;
  } mem_to_rf_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline-side bundle of the MEM stage.
//   master: stall controller / EX / data SRAM side (drives inputs to MEM)
//   slave : mem_stage itself
//   stall, flush, ex_to_mem_bus, data_sram_rdata, data_sram_data_ok -> MEM
//   stallreq_for_mem, mem_to_wb_bus, mem_to_rf_bus                   <- MEM
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [STALL_BUS_WD-1:0] stall;
  logic                    flush;
  ex_to_mem_t              ex_to_mem_bus;
  logic [DATA_WD-1:0]      data_sram_rdata;
  logic                    data_sram_data_ok;
  logic                    stallreq_for_mem;
  mem_to_wb_t              mem_to_wb_bus;
  mem_to_rf_t              mem_to_rf_bus;

  modport master (
    output stall, flush, ex_to_mem_bus, data_sram_rdata, data_sram_data_ok,
    input  stallreq_for_mem, mem_to_wb_bus, mem_to_rf_bus
  );

  modport slave (
    input  stall, flush, ex_to_mem_bus, data_sram_rdata, data_sram_data_ok,
    output stallreq_for_mem, mem_to_wb_bus, mem_to_rf_bus
  );

endinterface

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: selects the byte/halfword lane of a loaded word and
// sign- or zero-extends it.
//   i_ld_op  : load opcode (unknown codes act as LW)
//   i_addr   : low address bits; bit 0 ignored for halfwords
//   i_word   : raw SRAM word
//   o_word_c : aligned/extended result (combinational)
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]         i_ld_op,
  input  logic [1:0]         i_addr,
  input  logic [DATA_WD-1:0] i_word,
  output logic [DATA_WD-1:0] o_word_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction
  always_comb begin
    w_byte = 8'(i_word >> {i_addr, 3'b000});
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension
  always_comb begin
    o_word_c = i_word;
    case (i_ld_op)
      LD_LB:   o_word_c = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_word_c = {24'd0, w_byte};
      LD_LH:   o_word_c = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_word_c = {16'd0, w_half};
      LD_LW:   o_word_c = i_word;
      default: o_word_c = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Registers the EX bus, waits for the data
// SRAM response on loads (requesting a stall meanwhile), aligns load data and
// drives the WB and ID-forwarding buses.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : stall/flush, EX bus, SRAM response in; stall request,
//                 WB bus, forwarding bus out (combinational from the register)
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  bus
);

  ex_to_mem_t         r_ex_to_mem;
  mem_state_e         r_state;
  mem_state_e         w_state_nxt;
  logic               r_discard;
  logic               w_discard_nxt;
  logic [DATA_WD-1:0] r_rdata_buf;
  logic               w_buf_en;

  logic               w_advance;
  logic               w_bubble;
  logic               w_reg_load;
  logic               w_load_in;
  logic               w_ok_eff;
  logic               w_data_avail;
  logic [DATA_WD-1:0] w_load_word;
  logic [DATA_WD-1:0] w_aligned;
  logic [DATA_WD-1:0] w_wdata;
  logic               w_unused;

  assign w_advance  = (bus.stall[STALL_MEM] == NO_STOP);
  assign w_bubble   = (bus.stall[STALL_MEM] == STOP) && (bus.stall[STALL_WB] == NO_STOP);
  // Register is rewritten this cycle (new instruction or bubble)
  assign w_reg_load = w_advance | w_bubble;
  assign w_load_in  = w_advance & bus.ex_to_mem_bus.mem_re;
  // A response owed to a flushed load never completes the current one
  assign w_ok_eff   = bus.data_sram_data_ok & ~r_discard;

  // Pipeline register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex_to_mem <= '0;
    end else if (bus.flush) begin
      r_ex_to_mem <= '0;
    end else if (w_bubble) begin
      r_ex_to_mem <= '0;
    end else if (w_advance) begin
      r_ex_to_mem <= bus.ex_to_mem_bus;
    end
  end

  // FSM state, discard flag and response buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_discard   <= 1'b0;
      r_rdata_buf <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
      if (w_buf_en) begin
        r_rdata_buf <= bus.data_sram_rdata;
      end
    end
  end

  // Next state
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard & ~bus.data_sram_data_ok;
    w_buf_en      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
      // Flushing a waiting load leaves its response in flight unless it lands now
      if (r_state == ST_WAIT) begin
        w_discard_nxt = r_discard | ~bus.data_sram_data_ok;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_load_in) begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_reg_load) begin
            w_state_nxt = w_load_in ? ST_WAIT : ST_IDLE;
          end else if (w_ok_eff) begin
            w_state_nxt = ST_HOLD;
            w_buf_en    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_reg_load) begin
            w_state_nxt = w_load_in ? ST_WAIT : ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_data_avail = ((r_state == ST_WAIT) && w_ok_eff) || (r_state == ST_HOLD);
  assign w_load_word  = (r_state == ST_HOLD) ? r_rdata_buf : bus.data_sram_rdata;

  mem_stage_load_align u_load_align (
    .i_ld_op  (r_ex_to_mem.ld_op),
    .i_addr   (r_ex_to_mem.ex_result[1:0]),
    .i_word   (w_load_word),
    .o_word_c (w_aligned)
  );

  assign w_wdata = r_ex_to_mem.mem_re ? w_aligned : r_ex_to_mem.ex_result;

  // Outputs
  assign bus.stallreq_for_mem = r_ex_to_mem.mem_re & ~w_data_avail;

  assign bus.mem_to_wb_bus = '{
    hilo_bus: r_ex_to_mem.hilo_bus,
    pc:       r_ex_to_mem.pc,
    rf_we:    r_ex_to_mem.rf_we,
    rf_waddr: r_ex_to_mem.rf_waddr,
    rf_wdata: w_wdata
  };

  // Never forward a load result that has not arrived yet
  assign bus.mem_to_rf_bus = '{
    fwd_we:   r_ex_to_mem.rf_we & ~(r_ex_to_mem.mem_re & ~w_data_avail),
    rf_waddr: r_ex_to_mem.rf_waddr,
    rf_wdata: w_wdata
  };

  assign w_unused = ^{bus.stall[5], bus.stall[2:0], r_ex_to_mem.mem_we};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, between EX and WB. It registers the EX result bus and waits for the data-SRAM read response on loads, raising a stall request while it waits. It aligns and extends load data and produces the 136-bit bus that WB registers, plus a forwarding bus for ID.

## Interface
Parameters: none. Widths come from `defines.vh`: `EX_TO_MEM_WD` = 141, `MEM_TO_WB_WD` = 136, `StallBus` = 6.

- `clk` in 1 — clock; single clock domain.
- `resetn` in 1 — reset, asynchronous, active-low.
- `stall` in `StallBus` — stall vector from the stall controller; bit 3 = MEM, bit 4 = WB.
- `flush` in 1 — synchronous pipeline flush.
- `ex_to_mem_bus` in 141 — fields {hilo_bus[65:0], pc[31:0], mem_re, mem_we, ld_op[2:0], rf_we, rf_waddr[4:0], ex_result[31:0]}.
- `data_sram_rdata` in 32 — read data; valid only when `data_sram_data_ok`=1.
- `data_sram_data_ok` in 1 — single-cycle response strobe; one strobe per issued access.
- `stallreq_for_mem` out 1 — MEM requests a pipeline stall.
- `mem_to_wb_bus` out 136 — {hilo_bus, pc, rf_we, rf_waddr, rf_wdata}.
- `mem_to_rf_bus` out 38 — forwarding bus {fwd_we, rf_waddr, rf_wdata}.

## Operation
- Pipeline register `ex_to_mem_bus_r`, updated by priority:
  - async reset → 0;
  - `flush` → 0;
  - `stall[3]`=Stop and `stall[4]`=NoStop → 0 (bubble);
  - `stall[3]`=NoStop → `ex_to_mem_bus`;
  - otherwise hold.
- A load is present when `mem_re`=1 in the register. Stores never wait; their SRAM response is ignored.
- FSM states:
  - IDLE: no pending load.
  - WAIT: a load is in the register and no response has arrived yet.
  - HOLD: the response arrived while MEM was stalled; data is captured in `rdata_buf`.
- Transitions:
  - IDLE → WAIT when a load enters the register.
  - WAIT → HOLD on `data_ok` when the register does not advance that cycle.
  - WAIT or HOLD → IDLE, or WAIT if the entering instruction is a load, when the register advances.
  - Any state → IDLE on `flush`.
- `data_avail` = (state==WAIT and `data_ok`) or state==HOLD.
- `stallreq_for_mem` = load present and not `data_avail`. It depends combinationally on `data_ok`.
- Load data source is `data_sram_rdata` in WAIT and `rdata_buf` in HOLD. Lane selection uses `ex_result[1:0]`.
- `ld_op` encoding:
  - 000 LW: whole word.
  - 001 LB: byte at addr[1:0], sign-extended.
  - 010 LBU: byte, zero-extended.
  - 011 LH: half at addr[1], sign-extended.
  - 100 LHU: half, zero-extended.
  - Other codes behave as LW.
  - Misalignment is EX's responsibility; addr[0] is ignored for halfwords.
- `rf_wdata` = aligned load data if `mem_re`, else `ex_result`. `hilo_bus` and `pc` pass through unchanged.
- `fwd_we` = `rf_we` and not (`mem_re` and not `data_avail`), so ID never forwards stale load data.
- Discard flag:
  - Set when `flush` hits while in WAIT.
  - The next `data_ok` is consumed silently and clears the flag. It does not complete any newer load.
  - While the flag is set, a newly entered load stays in WAIT.

## Timing
- Reset: `mem_to_wb_bus`=0, `mem_to_rf_bus`=0, `stallreq_for_mem`=0; state IDLE, discard flag 0, `rdata_buf` 0.
- Non-load instructions: one cycle in MEM. The outputs are combinational from the register.
- Load issued in EX at cycle N with `data_ok` at N+1: no stall, and WB holds the result at N+2. Each cycle `data_ok` is late adds one stall cycle plus one WB bubble.
- `data_ok` in the same cycle as `flush`, while in WAIT: the response is discarded and the discard flag is not set.
- `data_ok` with no load pending and the discard flag clear (store response): ignored.
- `resetn` deasserted mid-WAIT: everything clears immediately. A late `data_ok` is ignored because the state is IDLE.

## Structure
- `defines.vh` holds `EX_TO_MEM_WD`, `MEM_TO_WB_WD`, `StallBus`, `Stop`/`NoStop`, and the LD_* opcode constants.
- One combinational sub-module, `load_align`: inputs ld_op, addr[1:0], word; output aligned word.
- FSM, discard flag, and `rdata_buf` live in `mem_stage`.

## Test plan
- ALU op: rf_we=1, waddr=5, ex_result=0x1234 → next cycle `mem_to_wb_bus` carries {we=1, r5, 0x1234}; stallreq stays 0.
- LB at addr 0x..03, rdata=0x80FF_FF7F, data_ok one cycle after entry → rf_wdata=0xFFFF_FF80. The same case as LBU → 0x0000_0080; no stall.
- LH at addr[1]=1, rdata=0x8001_0000, data_ok delayed 3 cycles → stallreq high 3 cycles, `fwd_we`=0 throughout, then rf_wdata=0xFFFF_8001.
- data_ok arrives while `stall[3]`=Stop held by the controller for 2 more cycles → state HOLD, buffered data appears on the bus when released, and stallreq is 0 during HOLD.
- `flush` during WAIT, then a new LW, then two data_ok strobes (0xAAAA_AAAA, 0x5555_5555) → the first is discarded and WB receives 0x5555_5555.
- `resetn` pulled low mid-WAIT → all outputs 0 immediately; a following data_ok is ignored.
